// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and line levels.
// Imported by the receiver top and its holding register.
package sipo_rx_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StData   = 2'd1,
      StParity = 2'd2,
      StStop   = 2'd3
   } state_e;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;

   // Bit counter must hold WIDTH itself so it never wraps inside a frame.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial line in, parallel word and status strobes out.
// master drives the line; slave is the receiver.
interface sipo_frame_rx_if #(
   parameter int unsigned WIDTH = 8
);

   logic             in;
   logic [WIDTH-1:0] out;
   logic             valid;
   logic             frame_err;

   modport master (
      output in,
      input  out,
      input  valid,
      input  frame_err
   );

   modport slave (
      input  in,
      output out,
      output valid,
      output frame_err
   );

endinterface

// File: rtl/sipo_shift.sv
// WIDTH-bit holding register, LSB-first serial load with shift enable.
// Async clear on rst.
module sipo_shift #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q, data_d;

   // New bits enter at the MSB and walk down, so the first bit lands at bit 0.
   always_comb begin
      data_d = data_q;
      if (shift_en_i) begin
         data_d = {bit_i, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Frame receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Emits a registered one-cycle valid or frame_err per frame.
module sipo_frame_rx
   import sipo_rx_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PARITY_EN = 1
) (
   input logic              clk,
   input logic              rst,
   sipo_frame_rx_if.slave   bus
);

   localparam int unsigned     CntW    = cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             par_q, par_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             shift_en;
   logic             frame_ok;
   logic [WIDTH-1:0] hold;

   sipo_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (shift_en),
      .bit_i      (bus.in),
      .data_o     (hold)
   );

   // With parity disabled par_q stays 0, so it cannot disturb the check.
   assign frame_ok = (bus.in == STOP_BIT) && ((PARITY_EN == 0) || !(^{hold, par_q}));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      par_d    = par_q;
      out_d    = out_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in == START_BIT) begin
               state_d = StData;
               cnt_d   = '0;
            end
         end
         StData: begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastIdx) begin
               state_d = (PARITY_EN != 0) ? StParity : StStop;
            end
         end
         StParity: begin
            par_d   = bus.in;
            state_d = StStop;
         end
         StStop: begin
            // A bad stop bit is dropped here; the start search resumes next edge.
            state_d = StIdle;
            if (frame_ok) begin
               out_d   = hold;
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = err_q;

endmodule
